// File: rtl/systolic_ws_tile_ctrl_if.sv
// Signal bundle between the job dispatcher / SRAM-PE datapath (master) and the
// weight-stationary tile controller (slave).
interface systolic_ws_tile_ctrl_if #(
    parameter int ROW_MAX = 8,
    parameter int LENGTH  = 8,
    parameter int COL_NUM = 8
);
    localparam int RA_W  = $clog2(ROW_MAX);
    localparam int ROW_W = $clog2(ROW_MAX + 1);
    localparam int IDX_W = $clog2(LENGTH);

    logic                    val_in;
    logic [ROW_W-1:0]        cfg_rows;
    logic                    rdy_in;
    logic                    busy;
    logic                    w_load_en;
    logic [IDX_W-1:0]        w_load_idx;
    logic [LENGTH-1:0]       rd_en;
    logic [LENGTH*RA_W-1:0]  rd_addr;
    logic [COL_NUM-1:0]      wr_en;
    logic [COL_NUM*RA_W-1:0] wr_addr;
    logic                    done;

    modport master (
        output val_in, cfg_rows,
        input  rdy_in, busy, w_load_en, w_load_idx,
        input  rd_en, rd_addr, wr_en, wr_addr, done
    );

    modport slave (
        input  val_in, cfg_rows,
        output rdy_in, busy, w_load_en, w_load_idx,
        output rd_en, rd_addr, wr_en, wr_addr, done
    );
endinterface

// File: rtl/systolic_ws_tile_ctrl.sv
// Weight-stationary systolic tile sequencer: weight preload, then skewed
// per-lane source reads and skewed per-column result writes, then a done pulse.
module systolic_ws_tile_ctrl #(
    parameter int ROW_MAX = 8,
    parameter int LENGTH  = 8,
    parameter int COL_NUM = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_ws_tile_ctrl_if.slave bus
);
    localparam int RA_W  = $clog2(ROW_MAX);
    localparam int ROW_W = $clog2(ROW_MAX + 1);
    localparam int IDX_W = $clog2(LENGTH);
    localparam int CNT_W = $clog2(LENGTH + COL_NUM + ROW_MAX + 1);
    // Write skew: LENGTH cycles through the array plus one output buffer stage.
    localparam int WR_DLY = LENGTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [ROW_W-1:0] rows_clamped;
    logic [CNT_W-1:0] rows_ext;
    logic             stream_last;

    assign rows_clamped = (bus.cfg_rows > ROW_W'(ROW_MAX)) ? ROW_W'(ROW_MAX) : bus.cfg_rows;
    assign rows_ext     = CNT_W'(rows_q);
    assign stream_last  = (cyc_q == CNT_W'(LENGTH + COL_NUM - 1) + rows_ext);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        rows_d  = rows_q;
        case (state_q)
            IDLE: begin
                if (bus.val_in) begin
                    rows_d  = rows_clamped;
                    cyc_d   = '0;
                    state_d = (rows_clamped == '0) ? DONE : LOAD_W;
                end
            end
            LOAD_W: begin
                if (cyc_q == CNT_W'(LENGTH - 1)) begin
                    cyc_d   = '0;
                    state_d = STREAM;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            STREAM: begin
                if (stream_last) begin
                    cyc_d   = '0;
                    state_d = DONE;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            rows_q  <= rows_d;
        end
    end

    logic [LENGTH-1:0]       rd_en_c;
    logic [LENGTH*RA_W-1:0]  rd_addr_c;
    logic [COL_NUM-1:0]      wr_en_c;
    logic [COL_NUM*RA_W-1:0] wr_addr_c;

    // Lane i reads rows cyc-i; column j writes rows cyc-WR_DLY-j. Addresses stay 0 when idle.
    always_comb begin
        rd_en_c   = '0;
        rd_addr_c = '0;
        wr_en_c   = '0;
        wr_addr_c = '0;
        if (state_q == STREAM) begin
            for (int i = 0; i < LENGTH; i++) begin
                if ((cyc_q >= CNT_W'(i)) && (cyc_q < CNT_W'(i) + rows_ext)) begin
                    rd_en_c[i]                = 1'b1;
                    rd_addr_c[i*RA_W +: RA_W] = RA_W'(cyc_q - CNT_W'(i));
                end
            end
            for (int j = 0; j < COL_NUM; j++) begin
                if ((cyc_q >= CNT_W'(WR_DLY + j)) && (cyc_q < CNT_W'(WR_DLY + j) + rows_ext)) begin
                    wr_en_c[j]                = 1'b1;
                    wr_addr_c[j*RA_W +: RA_W] = RA_W'(cyc_q - CNT_W'(WR_DLY + j));
                end
            end
        end
    end

    assign bus.rdy_in     = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.w_load_en  = (state_q == LOAD_W);
    assign bus.w_load_idx = (state_q == LOAD_W) ? cyc_q[IDX_W-1:0] : '0;
    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = rd_addr_c;
    assign bus.wr_en      = wr_en_c;
    assign bus.wr_addr    = wr_addr_c;
endmodule

// File: tb/tb_systolic_ws_tile_ctrl.sv
// Self-checking bench for systolic_ws_tile_ctrl: per-cycle traces after each accept
// are compared against an event-placement model of the job timeline.
module tb_systolic_ws_tile_ctrl;
    localparam int ROW_MAX = 8;
    localparam int LENGTH  = 4;
    localparam int COL_NUM = 4;
    localparam int RA_W    = $clog2(ROW_MAX);
    localparam int ROW_W   = $clog2(ROW_MAX + 1);
    localparam int IDX_W   = $clog2(LENGTH);
    localparam int NK      = 2 * LENGTH + COL_NUM + ROW_MAX + 3;
    localparam int NT      = 64;

    typedef struct packed {
        logic                    rdy;
        logic                    busy;
        logic                    wle;
        logic [IDX_W-1:0]        widx;
        logic [LENGTH-1:0]       rd_en;
        logic [LENGTH*RA_W-1:0]  rd_addr;
        logic [COL_NUM-1:0]      wr_en;
        logic [COL_NUM*RA_W-1:0] wr_addr;
        logic                    done;
    } snap_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    systolic_ws_tile_ctrl_if #(.ROW_MAX(ROW_MAX), .LENGTH(LENGTH), .COL_NUM(COL_NUM)) bus ();

    systolic_ws_tile_ctrl #(.ROW_MAX(ROW_MAX), .LENGTH(LENGTH), .COL_NUM(COL_NUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    snap_t tr[NT];

    function automatic snap_t sample();
        snap_t s;
        s.rdy     = bus.rdy_in;
        s.busy    = bus.busy;
        s.wle     = bus.w_load_en;
        s.widx    = bus.w_load_idx;
        s.rd_en   = bus.rd_en;
        s.rd_addr = bus.rd_addr;
        s.wr_en   = bus.wr_en;
        s.wr_addr = bus.wr_addr;
        s.done    = bus.done;
        return s;
    endfunction

    function automatic snap_t idle_snap();
        snap_t s;
        s     = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic int eff_rows(input int cfg);
        return (cfg > ROW_MAX) ? ROW_MAX : cfg;
    endfunction

    // Offset from accept to the done cycle.
    function automatic int done_offset(input int r);
        return (r == 0) ? 1 : (LENGTH + 1) + LENGTH + COL_NUM + r;
    endfunction

    // Expected outputs k cycles after the accept cycle of a job with r effective rows.
    // Row a of lane i is read at T0+i+a; row a of column j is written at T0+(LENGTH+1)+j+a.
    function automatic snap_t model(input int k, input int r);
        snap_t s;
        int    kd;
        int    t0;
        int    a;
        kd = done_offset(r);
        t0 = LENGTH + 1;
        if (k <= 0 || k > kd) return idle_snap();
        s      = '0;
        s.busy = 1'b1;
        if (k == kd) begin
            s.done = 1'b1;
            return s;
        end
        if (k <= LENGTH) begin
            s.wle  = 1'b1;
            s.widx = IDX_W'(k - 1);
            return s;
        end
        for (int i = 0; i < LENGTH; i++) begin
            a = k - t0 - i;
            if (a >= 0 && a < r) begin
                s.rd_en[i]                = 1'b1;
                s.rd_addr[i*RA_W +: RA_W] = RA_W'(a);
            end
        end
        for (int j = 0; j < COL_NUM; j++) begin
            a = k - t0 - (LENGTH + 1) - j;
            if (a >= 0 && a < r) begin
                s.wr_en[j]                = 1'b1;
                s.wr_addr[j*RA_W +: RA_W] = RA_W'(a);
            end
        end
        return s;
    endfunction

    // Present a job for one cycle, then scramble cfg_rows so only the latched value matters.
    task automatic start_job(input int cfg);
        @(negedge clk);
        bus.val_in   = 1'b1;
        bus.cfg_rows = ROW_W'(cfg);
        @(negedge clk);
        bus.val_in   = 1'b0;
        bus.cfg_rows = ROW_W'($urandom);
        tr[1] = sample();
    endtask

    task automatic capture(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            @(negedge clk);
            tr[k] = sample();
        end
    endtask

    task automatic test_reset();
        snap_t got;
        reset        = 1'b1;
        bus.val_in   = 1'b1;
        bus.cfg_rows = ROW_W'(3);
        repeat (3) @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== idle_snap()) $display("FAIL reset_hold got %h expected %h", got, idle_snap());
        else n_pass++;
        bus.val_in = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== idle_snap()) $display("FAIL reset_release got %h expected %h", got, idle_snap());
        else n_pass++;
    endtask

    task automatic test_full_rows();
        snap_t want;
        logic [3:0] pat;
        start_job(8);
        capture(2, NK);
        for (int k = 1; k <= NK; k++) begin
            want = model(k, 8);
            n_checks++;
            if (tr[k] !== want) $display("FAIL full_rows A+%0d got %h expected %h", k, tr[k], want);
            else n_pass++;
        end
        pat = {tr[4].rd_en[0], tr[5].rd_en[0], tr[12].rd_en[0], tr[13].rd_en[0]};
        n_checks++;
        if (pat !== 4'b0110) $display("FAIL full_rd0_window got %b expected 0110", pat); else n_pass++;
        pat = {tr[7].rd_en[3], tr[8].rd_en[3], tr[15].rd_en[3], tr[16].rd_en[3]};
        n_checks++;
        if (pat !== 4'b0110) $display("FAIL full_rd3_window got %b expected 0110", pat); else n_pass++;
        pat = {tr[9].wr_en[0], tr[10].wr_en[0], tr[17].wr_en[0], tr[18].wr_en[0]};
        n_checks++;
        if (pat !== 4'b0110) $display("FAIL full_wr0_window got %b expected 0110", pat); else n_pass++;
        pat = {tr[12].wr_en[3], tr[13].wr_en[3], tr[20].wr_en[3], tr[21].wr_en[3]};
        n_checks++;
        if (pat !== 4'b0110) $display("FAIL full_wr3_window got %b expected 0110", pat); else n_pass++;
        pat = {tr[20].done, tr[21].done, tr[22].done, tr[22].rdy};
        n_checks++;
        if (pat !== 4'b0101) $display("FAIL full_done_rdy got %b expected 0101", pat); else n_pass++;
        n_checks++;
        if (tr[17].wr_addr[0 +: RA_W] !== RA_W'(7))
            $display("FAIL full_wr0_last_addr got %0d expected 7", tr[17].wr_addr[0 +: RA_W]);
        else n_pass++;
    endtask

    task automatic test_short_rows();
        snap_t want;
        logic [3:0] pat;
        logic [3*RA_W-1:0] addrs;
        start_job(3);
        capture(2, 18);
        for (int k = 1; k <= 18; k++) begin
            want = model(k, 3);
            n_checks++;
            if (tr[k] !== want) $display("FAIL short_rows A+%0d got %h expected %h", k, tr[k], want);
            else n_pass++;
        end
        pat = {tr[4].rd_en[0], tr[5].rd_en[0], tr[7].rd_en[0], tr[8].rd_en[0]};
        n_checks++;
        if (pat !== 4'b0110) $display("FAIL short_rd0_window got %b expected 0110", pat); else n_pass++;
        pat = {tr[12].wr_en[3], tr[13].wr_en[3], tr[15].wr_en[3], tr[16].wr_en[3]};
        n_checks++;
        if (pat !== 4'b0110) $display("FAIL short_wr3_window got %b expected 0110", pat); else n_pass++;
        addrs = {tr[13].wr_addr[3*RA_W +: RA_W], tr[14].wr_addr[3*RA_W +: RA_W], tr[15].wr_addr[3*RA_W +: RA_W]};
        n_checks++;
        if (addrs !== {RA_W'(0), RA_W'(1), RA_W'(2)})
            $display("FAIL short_wr3_addrs got %h expected %h", addrs, {RA_W'(0), RA_W'(1), RA_W'(2)});
        else n_pass++;
        pat = {tr[15].done, tr[16].done, tr[17].done, tr[17].rdy};
        n_checks++;
        if (pat !== 4'b0101) $display("FAIL short_done got %b expected 0101", pat); else n_pass++;
    endtask

    task automatic test_zero_rows();
        snap_t want;
        logic  any_en;
        start_job(0);
        capture(2, 6);
        any_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            want = model(k, 0);
            any_en = any_en | tr[k].wle | (|tr[k].rd_en) | (|tr[k].wr_en);
            n_checks++;
            if (tr[k] !== want) $display("FAIL zero_rows A+%0d got %h expected %h", k, tr[k], want);
            else n_pass++;
        end
        n_checks++;
        if ({tr[1].done, tr[2].rdy, any_en} !== 3'b110)
            $display("FAIL zero_rows_summary got %b expected 110", {tr[1].done, tr[2].rdy, any_en});
        else n_pass++;
    endtask

    task automatic test_clamp();
        snap_t want;
        start_job(15);
        capture(2, NK);
        for (int k = 1; k <= NK; k++) begin
            want = model(k, ROW_MAX);
            n_checks++;
            if (tr[k] !== want) $display("FAIL clamp A+%0d got %h expected %h", k, tr[k], want);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        snap_t want;
        int r1, r2, k2, last;
        r1   = $urandom_range(1, ROW_MAX);
        r2   = $urandom_range(0, 15);
        k2   = done_offset(r1) + 1;
        last = k2 + done_offset(eff_rows(r2)) + 1;
        @(negedge clk);
        bus.val_in   = 1'b1;
        bus.cfg_rows = ROW_W'(r1);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            tr[k] = sample();
            if (k == 1) bus.cfg_rows = ROW_W'(r2);
            if (k == k2 + 1) bus.val_in = 1'b0;
        end
        for (int k = 1; k <= last; k++) begin
            want = (k <= k2) ? model(k, r1) : model(k - k2, eff_rows(r2));
            n_checks++;
            if (tr[k] !== want)
                $display("FAIL back_to_back r1=%0d r2=%0d A+%0d got %h expected %h", r1, r2, k, tr[k], want);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_job();
        snap_t want;
        int r;
        start_job(8);
        capture(2, 9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tr[10] = sample();
        capture(11, NK + 5);
        for (int k = 1; k <= NK + 5; k++) begin
            want = (k <= 9) ? model(k, 8) : idle_snap();
            n_checks++;
            if (tr[k] !== want) $display("FAIL reset_mid_job A+%0d got %h expected %h", k, tr[k], want);
            else n_pass++;
        end
        r = $urandom_range(1, ROW_MAX);
        start_job(r);
        capture(2, done_offset(r) + 2);
        for (int k = 1; k <= done_offset(r) + 2; k++) begin
            want = model(k, r);
            n_checks++;
            if (tr[k] !== want) $display("FAIL after_reset_job r=%0d A+%0d got %h expected %h", r, k, tr[k], want);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        snap_t want;
        int cfg, r, kd, a, bad, errs;
        int rd_cnt[LENGTH][ROW_MAX];
        int wr_cnt[COL_NUM][ROW_MAX];
        for (int job = 0; job < 12; job++) begin
            cfg = $urandom_range(0, 15);
            r   = eff_rows(cfg);
            kd  = done_offset(r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_job(cfg);
            capture(2, kd + 2);
            errs = 0;
            for (int k = 1; k <= kd + 2; k++) begin
                want = model(k, r);
                if (tr[k] !== want) begin
                    errs++;
                    if (errs == 1) $display("FAIL random_trace cfg=%0d A+%0d got %h expected %h", cfg, k, tr[k], want);
                end
            end
            n_checks++;
            if (errs == 0) n_pass++;
            bad = 0;
            for (int i = 0; i < LENGTH; i++) for (int b = 0; b < ROW_MAX; b++) rd_cnt[i][b] = 0;
            for (int j = 0; j < COL_NUM; j++) for (int b = 0; b < ROW_MAX; b++) wr_cnt[j][b] = 0;
            for (int k = 1; k <= kd + 2; k++) begin
                for (int i = 0; i < LENGTH; i++) if (tr[k].rd_en[i]) begin
                    a = int'(tr[k].rd_addr[i*RA_W +: RA_W]);
                    if (a >= r) bad++; else rd_cnt[i][a]++;
                end
                for (int j = 0; j < COL_NUM; j++) if (tr[k].wr_en[j]) begin
                    a = int'(tr[k].wr_addr[j*RA_W +: RA_W]);
                    if (a >= r) bad++; else wr_cnt[j][a]++;
                end
            end
            errs = 0;
            for (int i = 0; i < LENGTH; i++) for (int b = 0; b < r; b++) if (rd_cnt[i][b] != 1) errs++;
            for (int j = 0; j < COL_NUM; j++) for (int b = 0; b < r; b++) if (wr_cnt[j][b] != 1) errs++;
            n_checks++;
            if (errs != 0 || bad != 0)
                $display("FAIL random_scoreboard cfg=%0d got %0d miscounts %0d out-of-range expected 0 0", cfg, errs, bad);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected summary within budget");
        $fatal(1);
    end

    initial begin
        bus.val_in   = 1'b0;
        bus.cfg_rows = '0;
        test_reset();
        test_full_rows();
        test_short_rows();
        test_zero_rows();
        test_clamp();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
